// File: rtl/strip_fmap_writer_if.sv
// Pixel-stream and strip-BRAM write signals of the strip feature-map writer.
// master: pixel source / BRAM side; slave: the writer itself.
interface strip_fmap_writer_if #(
   parameter int unsigned DATA_W = 9,
   parameter int unsigned ADDR_W = 16
);
   logic                     s_valid;
   logic signed [DATA_W-1:0] s_data;
   logic                     s_ready;
   logic                     bram_we;
   logic        [ADDR_W-1:0] bram_addr;
   logic signed [DATA_W-1:0] bram_din;

   modport master (
      output s_valid,
      output s_data,
      input  s_ready,
      input  bram_we,
      input  bram_addr,
      input  bram_din
   );

   modport slave (
      input  s_valid,
      input  s_data,
      output s_ready,
      output bram_we,
      output bram_addr,
      output bram_din
   );
endinterface

// File: rtl/strip_fmap_writer.sv
// Producer side of the horizontal-strip feature-map BRAM. Writes one XSIZE x YSIZE strip from a
// raster pixel stream, flags strip_full for the conv unit and waits for its done before reloading.
// Optional feature: define STRIP_CHECKSUM_EN to add a 24-bit running sum of the written pixels.
module strip_fmap_writer #(
   parameter int unsigned XSIZE  = 224,
   parameter int unsigned YSIZE  = 30,
   parameter int unsigned DATA_W = 9,
   parameter int unsigned ADDR_W = 16
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               start_i,
   input  logic               consumer_done_i,
   strip_fmap_writer_if.slave bus,
   output logic               strip_full_o,
   output logic               busy_o,
   output logic [7:0]         strip_count_o
`ifdef STRIP_CHECKSUM_EN
   ,
   output logic [23:0]        checksum_o
`endif
);

   localparam int unsigned       ColW     = (XSIZE > 1) ? $clog2(XSIZE) : 1;
   localparam int unsigned       RowW     = $clog2(YSIZE + 1);
   localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(XSIZE * YSIZE - 1);
   localparam logic [ColW-1:0]   LastCol  = ColW'(XSIZE - 1);

   typedef enum logic [1:0] {
      StIdle,
      StLoad,
      StFull
   } state_e;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] ptr_q, ptr_d;
   logic [ColW-1:0]   col_q, col_d;
   logic [RowW-1:0]   row_q, row_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] din_q, din_d;
   logic              full_q, full_d;
   logic [7:0]        count_q, count_d;
   logic              accept;

   // Ready depends on state only, so the source never sees a combinational loop through us.
   assign bus.s_ready = (state_q == StLoad);
   assign accept      = bus.s_valid & bus.s_ready;

   assign bus.bram_we   = we_q;
   assign bus.bram_addr = addr_q;
   assign bus.bram_din  = din_q;
   assign strip_full_o  = full_q;
   assign busy_o        = (state_q != StIdle);
   assign strip_count_o = count_q;

   // Next-state logic: load sequencing, write-port staging and strip release.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      col_d   = col_q;
      row_d   = row_q;
      we_d    = 1'b0;
      addr_d  = addr_q;
      din_d   = din_q;
      full_d  = full_q;
      count_d = count_q;

      unique case (state_q)
         StIdle: begin
            if (start_i) begin
               state_d = StLoad;
            end
         end
         StLoad: begin
            if (accept) begin
               // The write lands one cycle after the accept.
               we_d   = 1'b1;
               addr_d = ptr_q;
               din_d  = bus.s_data;
               ptr_d  = ptr_q + 1'b1;
               if (col_q == LastCol) begin
                  col_d = '0;
                  row_d = row_q + 1'b1;
               end else begin
                  col_d = col_q + 1'b1;
               end
               if (ptr_q == LastAddr) begin
                  state_d = StFull;
               end
            end
         end
         StFull: begin
            if (consumer_done_i) begin
               full_d  = 1'b0;
               count_d = count_q + 8'd1;
               ptr_d   = '0;
               col_d   = '0;
               row_d   = '0;
               state_d = start_i ? StLoad : StIdle;
            end else begin
               // First FULL cycle still carries the final write; the flag follows it.
               full_d = 1'b1;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // State and output registers, cleared asynchronously.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= StIdle;
         ptr_q   <= '0;
         col_q   <= '0;
         row_q   <= '0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         din_q   <= '0;
         full_q  <= 1'b0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         col_q   <= col_d;
         row_q   <= row_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         din_q   <= din_d;
         full_q  <= full_d;
         count_q <= count_d;
      end
   end

`ifdef STRIP_CHECKSUM_EN
   logic [23:0] sum_q, sum_d;

   assign checksum_o = sum_q;

   // Running sign-extended sum of accepted pixels, restarted whenever a load begins.
   always_comb begin
      sum_d = sum_q;
      if ((state_q != StLoad) && (state_d == StLoad)) begin
         sum_d = '0;
      end else if (accept) begin
         sum_d = sum_q + 24'($signed(bus.s_data));
      end
   end

   // Checksum accumulator register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sum_q <= '0;
      end else begin
         sum_q <= sum_d;
      end
   end
`endif

endmodule

// File: tb/tb_strip_fmap_writer.sv
// Self-checking bench for strip_fmap_writer: behavioural strip model plus per-cycle compare.
module tb_strip_fmap_writer;
   localparam int unsigned XSIZE  = 224;
   localparam int unsigned YSIZE  = 30;
   localparam int unsigned DATA_W = 9;
   localparam int unsigned ADDR_W = 16;
   localparam int          NPIX   = XSIZE * YSIZE;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic       consumer_done = 1'b0;
   logic       strip_full;
   logic       busy;
   logic [7:0] strip_count;
`ifdef STRIP_CHECKSUM_EN
   logic [23:0] checksum;
`endif

   strip_fmap_writer_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

   strip_fmap_writer #(
      .XSIZE (XSIZE),
      .YSIZE (YSIZE),
      .DATA_W(DATA_W),
      .ADDR_W(ADDR_W)
   ) dut (
      .clk_i          (clk),
      .rst_ni         (rst_n),
      .start_i        (start),
      .consumer_done_i(consumer_done),
      .bus            (bus.slave),
      .strip_full_o   (strip_full),
      .busy_o         (busy),
      .strip_count_o  (strip_count)
`ifdef STRIP_CHECKSUM_EN
      ,
      .checksum_o     (checksum)
`endif
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Behavioural model: 0 idle, 1 loading, 2 strip held for the consumer.
   int                       m_mode;
   int                       m_ptr;
   bit                       m_we;
   int                       m_addr;
   logic signed [DATA_W-1:0] m_din;
   bit                       m_full;
   int                       m_count;
   logic [23:0]              m_sum;
   bit                       m_acc;
   logic signed [DATA_W-1:0] img_model [NPIX];
   logic signed [DATA_W-1:0] img_dut   [NPIX];

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_mode  = 0;
         m_ptr   = 0;
         m_we    = 0;
         m_addr  = 0;
         m_din   = '0;
         m_full  = 0;
         m_count = 0;
         m_sum   = '0;
      end else begin
         m_acc = bus.s_valid && (m_mode == 1);
         m_we  = m_acc;
         if (m_acc) begin
            m_addr          = m_ptr;
            m_din           = bus.s_data;
            img_model[m_ptr] = bus.s_data;
            m_sum           = m_sum + 24'($signed(bus.s_data));
            m_ptr++;
            if (m_ptr == NPIX) m_mode = 2;
         end else if (m_mode == 0) begin
            if (start) begin
               m_mode = 1;
               m_sum  = '0;
            end
         end else if (m_mode == 2) begin
            if (consumer_done) begin
               m_full  = 0;
               m_count = (m_count + 1) % 256;
               m_ptr   = 0;
               if (start) begin
                  m_mode = 1;
                  m_sum  = '0;
               end else begin
                  m_mode = 0;
               end
            end else begin
               m_full = 1;
            end
         end
      end
   end

   // Capture what the DUT actually writes into the strip BRAM.
   always @(posedge clk) begin
      if (rst_n && bus.bram_we === 1'b1 && bus.bram_addr < ADDR_W'(NPIX))
         img_dut[bus.bram_addr] = bus.bram_din;
   end

   // Compare process: every output, every cycle.
   bit img_checked = 0;
   always @(negedge clk) begin
      chk("s_ready", bus.s_ready, m_mode == 1);
      chk("bram_we", bus.bram_we, m_we);
      chk("bram_addr", bus.bram_addr, m_addr);
      chk("bram_din", bus.bram_din, m_din);
      chk("strip_full", strip_full, m_full);
      chk("busy", busy, m_mode != 0);
      chk("strip_count", strip_count, m_count);
`ifdef STRIP_CHECKSUM_EN
      if (m_full) chk("checksum", checksum, m_sum);
`endif
      if (m_full && !img_checked) begin
         int bad;
         bad = 0;
         for (int i = 0; i < NPIX; i++) if (img_dut[i] !== img_model[i]) bad++;
         chk("strip_image_bad_words", bad, 0);
         img_checked = 1;
      end
      if (!m_full) img_checked = 0;
   end

   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   task automatic load_random(input int budget);
      int n;
      n = 0;
      while (m_mode != 2 && n < budget) begin
         bus.s_valid   = ($urandom_range(0, 3) != 0);
         bus.s_data    = DATA_W'($urandom);
         start         = $urandom_range(0, 1);
         consumer_done = $urandom_range(0, 1);
         cyc();
         n++;
      end
      start         = 1'b0;
      consumer_done = 1'b0;
      if (m_mode != 2) begin
         n_err++;
         $display("FAIL load_timeout: got %0d pixels, expected %0d", m_ptr, NPIX);
      end
   endtask

   initial begin
      logic signed [DATA_W-1:0] e;
      int writes;
      bit pat [4];
      bus.s_valid = 1'b0;
      bus.s_data  = '0;
      repeat (2) cyc();
      chk("rst_s_ready", bus.s_ready, 0);
      chk("rst_bram_we", bus.bram_we, 0);
      chk("rst_bram_addr", bus.bram_addr, 0);
      chk("rst_strip_full", strip_full, 0);
      chk("rst_busy", busy, 0);
      chk("rst_strip_count", strip_count, 0);
      rst_n = 1'b1;
      cyc();

      // Strip 1: continuous stream, data = address[8:0].
      start = 1'b1;
      cyc();
      start = 1'b0;
      for (int i = 0; i < NPIX; i++) begin
         bus.s_valid = 1'b1;
         bus.s_data  = DATA_W'(i);
         cyc();
      end
      // Source keeps pushing while the strip is held.
      for (int i = 0; i < 50; i++) begin
         bus.s_data = DATA_W'($urandom);
         cyc();
      end
      bus.s_valid = 1'b0;
      chk("s1_strip_full", strip_full, 1);
      chk("s1_count_before_done", strip_count, 0);
      e = DATA_W'(0);
      chk("s1_word0", img_dut[0], e);
      e = DATA_W'(224);
      chk("s1_row_wrap_word224", img_dut[224], e);
      e = DATA_W'(63);
      chk("s1_last_word6719", img_dut[NPIX-1], e);

      // Release with start held: straight back into LOAD.
      consumer_done = 1'b1;
      start         = 1'b1;
      cyc();
      consumer_done = 1'b0;
      start         = 1'b0;
      chk("s1_count_after_done", strip_count, 1);
      chk("s2_ready_after_release", bus.s_ready, 1);
      bus.s_valid = 1'b1;
      bus.s_data  = DATA_W'($urandom);
      cyc();
      chk("s2_first_we", bus.bram_we, 1);
      chk("s2_first_addr", bus.bram_addr, 0);

      // Stall pattern 1,0,0,1: two writes at consecutive addresses.
      pat    = '{1'b1, 1'b0, 1'b0, 1'b1};
      writes = 0;
      for (int k = 0; k < 4; k++) begin
         bus.s_valid = pat[k];
         bus.s_data  = DATA_W'($urandom);
         cyc();
         writes += int'(bus.bram_we);
      end
      chk("stall_writes", writes, 2);
      chk("stall_last_addr", bus.bram_addr, 2);

      load_random(40000);
      repeat ($urandom_range(1, 20)) begin
         bus.s_valid = $urandom_range(0, 1);
         bus.s_data  = DATA_W'($urandom);
         cyc();
      end
      consumer_done = 1'b1;
      cyc();
      consumer_done = 1'b0;
      bus.s_valid   = 1'b0;
      chk("s2_idle_busy", busy, 0);
      chk("s2_count", strip_count, 2);

      // Strip 3: reset dropped mid-load at pointer 3000.
      start = 1'b1;
      cyc();
      start = 1'b0;
      for (int n = 0; n < 20000 && m_ptr != 3000; n++) begin
         bus.s_valid = ($urandom_range(0, 3) != 0);
         bus.s_data  = DATA_W'($urandom);
         cyc();
      end
      #1 rst_n = 1'b0;
      #1;
      chk("arst_s_ready", bus.s_ready, 0);
      chk("arst_bram_we", bus.bram_we, 0);
      chk("arst_bram_addr", bus.bram_addr, 0);
      chk("arst_bram_din", bus.bram_din, 0);
      chk("arst_strip_full", strip_full, 0);
      chk("arst_busy", busy, 0);
      chk("arst_strip_count", strip_count, 0);
      bus.s_valid = 1'b0;
      cyc();
      rst_n = 1'b1;

      // Strip 4: all -1 pixels, restarting at address 0.
      start       = 1'b1;
      bus.s_valid = 1'b1;
      bus.s_data  = '1;
      cyc();
      start = 1'b0;
      cyc();
      chk("s4_first_we", bus.bram_we, 1);
      chk("s4_first_addr", bus.bram_addr, 0);
      chk("s4_count", strip_count, 0);
      for (int n = 0; n < NPIX + 10 && m_mode != 2; n++) cyc();
      bus.s_valid = 1'b0;
      cyc();
      cyc();
      chk("s4_strip_full", strip_full, 1);
`ifdef STRIP_CHECKSUM_EN
      chk("s4_checksum_minus6720", checksum, 24'hFFE5C0);
`endif
      consumer_done = 1'b1;
      cyc();
      consumer_done = 1'b0;
      cyc();
      chk("s4_count_after_done", strip_count, 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
